// File: rtl/alu_pkg.sv
// Shared types for the 4-bit ALU and its self-test sequencer.
// Opcode encodings, opcode type and BIST state enum.
package alu_pkg;

  localparam int ALU_W = 4;

  typedef logic [2:0] alu_op_t;

  localparam alu_op_t OP_ADD = 3'd0;
  localparam alu_op_t OP_SUB = 3'd1;
  localparam alu_op_t OP_AND = 3'd2;
  localparam alu_op_t OP_OR  = 3'd3;
  localparam alu_op_t OP_XOR = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } bist_state_t;

  function automatic logic sat_full(
    input logic [7:0] cnt
  );
    return &cnt;
  endfunction

endpackage

// File: rtl/alu_bist_if.sv
// Operand/result bus between the BIST sequencer and the ALU.
// master drives operands, slave returns result and flags.
interface alu_bist_if;
  import alu_pkg::*;

  logic [ALU_W-1:0] alu_a;
  logic [ALU_W-1:0] alu_b;
  alu_op_t          alu_op;
  logic [ALU_W-1:0] alu_result;
  logic             alu_cout;
  logic             alu_zero;

  modport master (
    output alu_a,
    output alu_b,
    output alu_op,
    input  alu_result,
    input  alu_cout,
    input  alu_zero
  );

  modport slave (
    input  alu_a,
    input  alu_b,
    input  alu_op,
    output alu_result,
    output alu_cout,
    output alu_zero
  );

endinterface

// File: rtl/alu_ref_model.sv
// Combinational golden model of the 4-bit ALU contract.
// Invalid opcodes yield zero result and no carry.
module alu_ref_model
  import alu_pkg::*;
(
  input  alu_op_t          op,
  input  logic [ALU_W-1:0] a,
  input  logic [ALU_W-1:0] b,
  output logic [ALU_W-1:0] result,
  output logic             cout,
  output logic             zero
);

  logic [ALU_W:0] sum;

  // Decode opcode into a carry-extended result.
  always_comb begin
    sum = '0;
    unique case (1'b1)
      (op == OP_ADD): sum = {1'b0, a} + {1'b0, b};
      (op == OP_SUB): sum = {1'b0, a} - {1'b0, b};
      (op == OP_AND): sum = {1'b0, a & b};
      (op == OP_OR):  sum = {1'b0, a | b};
      (op == OP_XOR): sum = {1'b0, a ^ b};
      default:        sum = '0;
    endcase
  end

  assign result = sum[ALU_W-1:0];
  assign cout   = sum[ALU_W];
  assign zero   = (sum[ALU_W-1:0] == '0);

endmodule

// File: rtl/alu_bist.sv
// Self-test sequencer: sweeps op/a/b through the ALU and checks it.
// ALU_BIST_STOP_ON_FAIL_EN ends the sweep at the first mismatch.
module alu_bist
  import alu_pkg::*;
#(
  parameter alu_op_t OP_MAX = 3'd5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  alu_bist_if.master       alu,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [7:0]       err_count,
  output logic             fail_valid,
  output alu_op_t          first_fail_op,
  output logic [ALU_W-1:0] first_fail_a,
  output logic [ALU_W-1:0] first_fail_b
);

  bist_state_t      state;
  logic [ALU_W-1:0] exp_result;
  logic             exp_cout;
  logic             exp_zero;
  logic             mism;
  logic             last;
  logic [7:0]       err_next;

  alu_ref_model u_ref (
    .op     (alu.alu_op),
    .a      (alu.alu_a),
    .b      (alu.alu_b),
    .result (exp_result),
    .cout   (exp_cout),
    .zero   (exp_zero)
  );

  assign mism = {alu.alu_result, alu.alu_cout, alu.alu_zero}
             != {exp_result, exp_cout, exp_zero};

  assign last = (alu.alu_op == OP_MAX)
             && (&alu.alu_a) && (&alu.alu_b);

  assign err_next = (mism && !sat_full(err_count))
                  ? err_count + 8'd1 : err_count;

  // Sweep FSM with vector counters, compare and first-fail capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      alu.alu_a     <= '0;
      alu.alu_b     <= '0;
      alu.alu_op    <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      err_count     <= '0;
      fail_valid    <= 1'b0;
      first_fail_op <= '0;
      first_fail_a  <= '0;
      first_fail_b  <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            state         <= ST_RUN;
            busy          <= 1'b1;
            pass          <= 1'b0;
            err_count     <= '0;
            fail_valid    <= 1'b0;
            first_fail_op <= '0;
            first_fail_a  <= '0;
            first_fail_b  <= '0;
            alu.alu_a     <= '0;
            alu.alu_b     <= '0;
            alu.alu_op    <= '0;
          end
        end
        ST_RUN: begin
          err_count <= err_next;
          if (mism && !fail_valid) begin
            fail_valid    <= 1'b1;
            first_fail_op <= alu.alu_op;
            first_fail_a  <= alu.alu_a;
            first_fail_b  <= alu.alu_b;
          end
`ifdef ALU_BIST_STOP_ON_FAIL_EN
          if (mism) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= 1'b0;
          end else
`endif
          if (last) begin
            state      <= ST_DONE;
            busy       <= 1'b0;
            done       <= 1'b1;
            pass       <= (err_next == '0);
            alu.alu_a  <= '0;
            alu.alu_b  <= '0;
            alu.alu_op <= '0;
          end else begin
            if ((&alu.alu_a) && (&alu.alu_b))
              alu.alu_op <= alu.alu_op + 3'd1;
            {alu.alu_a, alu.alu_b} <=
              {alu.alu_a, alu.alu_b} + 8'd1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_bist.sv
// Directed bench for alu_bist with a fault-injectable behavioural ALU.
// Second instance exercises OP_MAX = 0.
module tb_alu_bist;

`ifdef ALU_BIST_STOP_ON_FAIL_EN
  localparam int N_ADD  = 32;
  localparam int E_ADD  = 1;
  localparam int N_STK  = 2;
  localparam int E_STK  = 1;
  localparam int N_SUB  = 257;
  localparam int E_SUB  = 1;
  localparam int N1_ADD = 32;
`else
  localparam int N_ADD  = 1536;
  localparam int E_ADD  = 120;
  localparam int N_STK  = 1536;
  localparam int E_STK  = 255;
  localparam int N_SUB  = 1536;
  localparam int E_SUB  = 255;
  localparam int N1_ADD = 256;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start0 = 1'b0;
  logic start1 = 1'b0;
  int   fault = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic       busy0, done0, pass0, fv0;
  logic [7:0] err0;
  logic [2:0] ffop0;
  logic [3:0] ffa0, ffb0;
  logic       busy1, done1, pass1, fv1;
  logic [7:0] err1;
  logic [2:0] ffop1;
  logic [3:0] ffa1, ffb1;

  alu_bist_if if0 ();
  alu_bist_if if1 ();

  always #5 clk = ~clk;

  alu_bist u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .alu(if0.master),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
    .fail_valid(fv0), .first_fail_op(ffop0),
    .first_fail_a(ffa0), .first_fail_b(ffb0)
  );

  alu_bist #(.OP_MAX(3'd0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .alu(if1.master),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .fail_valid(fv1), .first_fail_op(ffop1),
    .first_fail_a(ffa1), .first_fail_b(ffb1)
  );

  function automatic logic [5:0] alu_fn(
    input logic [2:0] op, input logic [3:0] a,
    input logic [3:0] b, input int f
  );
    logic [4:0] s;
    logic [3:0] r;
    logic       c;
    case (op)
      3'd0:    s = {1'b0, a} + {1'b0, b};
      3'd1:    s = {1'b0, a} - {1'b0, b};
      3'd2:    s = {1'b0, a & b};
      3'd3:    s = {1'b0, a | b};
      3'd4:    s = {1'b0, a ^ b};
      default: s = 5'd0;
    endcase
    r = s[3:0];
    c = s[4];
    if (f == 1 && op == 3'd0) c = 1'b0;
    if (f == 2) r = 4'd0;
    if (f == 3 && op == 3'd1) c = ~c;
    return {r, c, (r == 4'd0)};
  endfunction

  always_comb
    {if0.alu_result, if0.alu_cout, if0.alu_zero} =
      alu_fn(if0.alu_op, if0.alu_a, if0.alu_b, fault);

  always_comb
    {if1.alu_result, if1.alu_cout, if1.alu_zero} =
      alu_fn(if1.alu_op, if1.alu_a, if1.alu_b, fault);

  task automatic check(
    input string t, input logic [31:0] obs, input logic [31:0] exp
  );
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", t, obs, exp);
    end
  endtask

  task automatic sweep(
    input int sel, input string t, input int rep,
    input int en, input logic ep, input int ee, input logic efv,
    input int eop, input int ea, input int eb
  );
    int n;
    n = 0;
    @(negedge clk);
    if (sel == 1) start1 = 1'b1; else start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
    while ((sel == 1 ? busy1 : busy0) && n < 5000) begin
      if (sel == 1) start1 = (n == rep); else start0 = (n == rep);
      n++;
      @(negedge clk);
    end
    start0 = 1'b0;
    start1 = 1'b0;
    check({t, "_busy_cycles"}, n, en);
    check({t, "_done"}, sel == 1 ? done1 : done0, 1);
    check({t, "_pass"}, sel == 1 ? pass1 : pass0, ep);
    check({t, "_err"}, sel == 1 ? err1 : err0, ee);
    check({t, "_fv"}, sel == 1 ? fv1 : fv0, efv);
    check({t, "_ffop"}, sel == 1 ? ffop1 : ffop0, eop);
    check({t, "_ffa"}, sel == 1 ? ffa1 : ffa0, ea);
    check({t, "_ffb"}, sel == 1 ? ffb1 : ffb0, eb);
    @(negedge clk);
    check({t, "_done_drop"}, sel == 1 ? done1 : done0, 0);
    check({t, "_pass_hold"}, sel == 1 ? pass1 : pass0, ep);
  endtask

  task automatic check_reset(input string t);
    check({t, "_busy"}, busy0, 0);
    check({t, "_done"}, done0, 0);
    check({t, "_pass"}, pass0, 0);
    check({t, "_err"}, err0, 0);
    check({t, "_fv"}, fv0, 0);
    check({t, "_ff"}, {ffop0, ffa0, ffb0}, 0);
    check({t, "_vec"}, {if0.alu_op, if0.alu_a, if0.alu_b}, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_reset("rst");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset("idle");

    fault = 0;
    sweep(0, "good", -1, 1536, 1, 0, 0, 0, 0, 0);
    sweep(0, "restart", 100, 1536, 1, 0, 0, 0, 0, 0);

    fault = 1;
    sweep(0, "addc", -1, N_ADD, 0, E_ADD, 1, 0, 1, 15);
    fault = 2;
    sweep(0, "stuck", -1, N_STK, 0, E_STK, 1, 0, 0, 1);
    fault = 3;
    sweep(0, "subc", -1, N_SUB, 0, E_SUB, 1, 1, 0, 0);

    fault = 0;
    @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (499) @(negedge clk);
    check("mid_busy", busy0, 1);
    rst_n = 1'b0;
    #1;
    check_reset("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    sweep(0, "post_rst", -1, 1536, 1, 0, 0, 0, 0, 0);

    sweep(1, "op0_good", -1, 256, 1, 0, 0, 0, 0, 0);
    fault = 1;
    sweep(1, "op0_addc", -1, N1_ADD, 0, E_ADD, 1, 0, 1, 15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
